// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: A = a + b*w, B = a - b*w.
// Four register stages, optional halving, saturation with sticky ovf.
module fft_butterfly #(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*DW-1:0]   a_in,
  input  logic [2*DW-1:0]   b_in,
  input  logic [2*DW-1:0]   w_in,
  input  logic              scale,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   A_out,
  output logic [2*DW-1:0]   B_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int PW = 2 * DW;
  localparam int XW = DW + 2;

  logic stall, adv;

  logic             v1, v2, v3;
  logic [PW-1:0]    a1, b1, w1, a2, a3;
  logic             sc1, sc2, sc3;
  logic [TAG_W-1:0] t1, t2, t3;

  logic signed [PW-1:0] prr, pii, pri, pir;
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x;
  logic signed [PW:0]   dr, di;
  logic signed [XW-1:0] pr3, pi3, pr_n, pi_n;
  logic signed [XW-1:0] ar_x, ai_x;
  logic [DW:0]          ra, ia, rb, ib;
  logic                 sat_any;

  // Halve (floor) when scaling, then clamp; MSB of result flags clamping.
  function automatic logic [DW:0] fin(
    input logic signed [XW-1:0] x,
    input logic                 sc
  );
    logic signed [XW-1:0] y;
    y = sc ? (x >>> 1) : x;
    if (y[XW-1:DW-1] == 3'b000 || y[XW-1:DW-1] == 3'b111)
      return {1'b0, y[DW-1:0]};
    return {1'b1, y[XW-1], {(DW-1){~y[XW-1]}}};
  endfunction

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  assign br_x = PW'($signed(b1[PW-1:DW]));
  assign bi_x = PW'($signed(b1[DW-1:0]));
  assign wr_x = PW'($signed(w1[PW-1:DW]));
  assign wi_x = PW'($signed(w1[DW-1:0]));

  assign dr   = (PW+1)'(prr) - (PW+1)'(pii);
  assign di   = (PW+1)'(pri) + (PW+1)'(pir);
  assign pr_n = XW'(dr >>> FRAC);
  assign pi_n = XW'(di >>> FRAC);

  assign ar_x = XW'($signed(a3[PW-1:DW]));
  assign ai_x = XW'($signed(a3[DW-1:0]));

  assign ra = fin(ar_x + pr3, sc3);
  assign ia = fin(ai_x + pi3, sc3);
  assign rb = fin(ar_x - pr3, sc3);
  assign ib = fin(ai_x - pi3, sc3);

  assign sat_any = ra[DW] | ia[DW] | rb[DW] | ib[DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      A_out     <= '0;
      B_out     <= '0;
      tag_out   <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      A_out     <= {ra[DW-1:0], ia[DW-1:0]};
      B_out     <= {rb[DW-1:0], ib[DW-1:0]};
      tag_out   <= t3;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a1  <= a_in;
      b1  <= b_in;
      w1  <= w_in;
      sc1 <= scale;
      t1  <= tag_in;
      prr <= br_x * wr_x;
      pii <= bi_x * wi_x;
      pri <= br_x * wi_x;
      pir <= bi_x * wr_x;
      a2  <= a1;
      sc2 <= sc1;
      t2  <= t1;
      pr3 <= pr_n;
      pi3 <= pi_n;
      a3  <= a2;
      sc3 <= sc2;
      t3  <= t2;
    end
  end

  // A saturating load wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (adv && v3 && sat_any)
      ovf <= 1'b1;
    else if (clr_ovf)
      ovf <= 1'b0;
  end

endmodule
